// File: rtl/data_sram_responder_pkg.sv
// Shared types for the data SRAM responder: transfer-size encoding, the queued
// response entry layout and the byte-lane merge used on writes.
package data_sram_responder_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_e;

    typedef struct packed {
        logic              isWrite;
        size_e             size;
        logic [DATA_W-1:0] rdata;
    } resp_entry_t;

    // wstrb is authoritative: lanes with a clear strobe keep their old byte.
    function automatic logic [DATA_W-1:0] mergeBytes(input logic [DATA_W-1:0] oldWord,
                                                     input logic [DATA_W-1:0] newWord,
                                                     input logic [3:0]        strb);
        logic [DATA_W-1:0] merged;
        merged = oldWord;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) merged[8*b +: 8] = newWord[8*b +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/sram_resp_queue.sv
// In-order response FIFO; every slot carries a saturating countdown and the
// head may retire only once its countdown has reached zero.
module sram_resp_queue
    import data_sram_responder_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int DELAY_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push_i,
    input  resp_entry_t        pushEntry_i,
    input  logic [DELAY_W-1:0] pushDelay_i,
    input  logic               pop_i,
    output logic               full_o,
    output logic               empty_o,
    output logic               headReady_o,
    output resp_entry_t        headEntry_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    resp_entry_t        entry_q [DEPTH];
    logic [DELAY_W-1:0] delay_q [DEPTH];
    logic [PTR_W-1:0]   headPtr_q;
    logic [PTR_W-1:0]   tailPtr_q;
    logic [CNT_W-1:0]   count_q;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            headPtr_q <= '0;
            tailPtr_q <= '0;
            count_q   <= '0;
            for (int i = 0; i < DEPTH; i++) delay_q[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (delay_q[i] != '0) delay_q[i] <= delay_q[i] - 1'b1;
            end
            // A fresh push overrides the countdown of the slot it lands in.
            if (push_i) begin
                entry_q[tailPtr_q] <= pushEntry_i;
                delay_q[tailPtr_q] <= pushDelay_i;
                tailPtr_q          <= nextPtr(tailPtr_q);
            end
            if (pop_i) headPtr_q <= nextPtr(headPtr_q);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign full_o      = (count_q == CNT_W'(DEPTH));
    assign empty_o     = (count_q == '0);
    assign headReady_o = ~empty_o & (delay_q[headPtr_q] == '0);
    assign headEntry_o = entry_q[headPtr_q];

endmodule

// File: rtl/data_sram_responder.sv
// Word-addressed local data memory behind the SRAM-like bus with bounded, in-order
// responses. Define DATA_SRAM_RESP_RAND_DELAY_EN for LFSR-randomised addr_ok and latency.
module data_sram_responder
    import data_sram_responder_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int OUTSTANDING = 2,
    parameter int LATENCY     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata
);

`ifdef DATA_SRAM_RESP_RAND_DELAY_EN
    localparam int EXTRA_MAX = 3;
`else
    localparam int EXTRA_MAX = 0;
`endif
    localparam int DELAY_W = $clog2(LATENCY + EXTRA_MAX + 1) + 1;

    logic [31:0]        mem_q [2**ADDR_W];
    logic [ADDR_W-1:0]  wordIdx;
    logic               accept;
    logic               retire;
    logic               addrGate;
    logic [1:0]         extraDelay;
    logic               qFull;
    logic               qEmpty;
    logic               headReady;
    resp_entry_t        headEntry;
    resp_entry_t        pushEntry;
    logic [DELAY_W-1:0] pushDelay;
    logic               unusedBits;

`ifdef DATA_SRAM_RESP_RAND_DELAY_EN
    logic [15:0] lfsr_q;

    // Fibonacci LFSR with taps 16,14,13,11, free-running from reset.
    always_ff @(posedge clk) begin
        if (reset) lfsr_q <= 16'hACE1;
        else       lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    assign addrGate   = lfsr_q[0];
    assign extraDelay = lfsr_q[2:1];
`else
    assign addrGate   = 1'b1;
    assign extraDelay = 2'b00;
`endif

    assign wordIdx = data_sram_addr[ADDR_W+1:2];

    // A full queue may still accept when its head leaves in the same cycle.
    assign data_sram_addr_ok = ~reset & addrGate & (~qFull | headReady);
    assign accept            = data_sram_req & data_sram_addr_ok;
    assign retire            = ~reset & headReady;

    assign pushEntry.isWrite = data_sram_wr;
    assign pushEntry.size    = size_e'(data_sram_size);
    assign pushEntry.rdata   = data_sram_wr ? '0 : mem_q[wordIdx];
    assign pushDelay         = DELAY_W'(LATENCY - 1) + DELAY_W'(extraDelay);

    always_ff @(posedge clk) begin
        if (accept && data_sram_wr) begin
            mem_q[wordIdx] <= mergeBytes(mem_q[wordIdx], data_sram_wdata, data_sram_wstrb);
        end
    end

    sram_resp_queue #(
        .DEPTH   (OUTSTANDING),
        .DELAY_W (DELAY_W)
    ) u_queue (
        .clk         (clk),
        .reset       (reset),
        .push_i      (accept),
        .pushEntry_i (pushEntry),
        .pushDelay_i (pushDelay),
        .pop_i       (retire),
        .full_o      (qFull),
        .empty_o     (qEmpty),
        .headReady_o (headReady),
        .headEntry_o (headEntry)
    );

    assign data_sram_data_ok = retire;
    assign data_sram_rdata   = (retire && !headEntry.isWrite) ? headEntry.rdata : '0;

    assign unusedBits = ^{qEmpty, headEntry.size, data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

endmodule
